// File: rtl/alu_unit.sv
// alu_unit: two-stage integer ALU/branch-compare unit with a result FIFO feeding the CDB
module alu_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             flag_alu,
    input  logic [5:0]       op_alu,
    input  logic [31:0]      rs1_alu,
    input  logic [31:0]      rs2_alu,
    input  logic [ROB_W-1:0] rob_alu,
    output logic             alu_busy,
    output logic             alu_ans_flag,
    output logic [ROB_W-1:0] alu_ans_reorder,
    output logic [31:0]      alu_ans,
    input  logic             cdb_grant
);
    localparam int PW = $clog2(FIFO_DEPTH);
    logic             e1_valid;
    logic [5:0]       e1_op;
    logic [31:0]      e1_a, e1_b, res;
    logic [ROB_W-1:0] e1_tag;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;
    logic [31:0]      mem_ans [FIFO_DEPTH];
    logic [ROB_W-1:0] mem_tag [FIFO_DEPTH];
    logic [4:0]       sh;
    logic             lt, ltu, go, accept, push, pop;
    assign go = rdy && !flush;
    // E1 is counted as a reserved slot so an accepted issue always finds room
    assign alu_busy = ({1'b0, count} + (PW+2)'(e1_valid)) >= (PW+2)'(FIFO_DEPTH);
    assign alu_ans_flag = count != '0;
    assign accept = go && flag_alu && !alu_busy;
    assign push = go && e1_valid;
    assign pop = go && alu_ans_flag && cdb_grant;
    assign alu_ans = alu_ans_flag ? mem_ans[rd_ptr] : '0;
    assign alu_ans_reorder = alu_ans_flag ? mem_tag[rd_ptr] : '0;
    assign sh = e1_b[4:0];
    assign lt = $signed(e1_a) < $signed(e1_b);
    assign ltu = e1_a < e1_b;
    always_comb begin
        res = '0;
        case (e1_op)
            6'd0: res = e1_a + e1_b;
            6'd1: res = e1_a - e1_b;
            6'd2: res = e1_a & e1_b;
            6'd3: res = e1_a | e1_b;
            6'd4: res = e1_a ^ e1_b;
            6'd5: res = e1_a << sh;
            6'd6: res = e1_a >> sh;
            6'd7: res = $signed(e1_a) >>> sh;
            6'd8, 6'd12: res = {31'b0, lt};
            6'd9, 6'd14: res = {31'b0, ltu};
            6'd10: res = {31'b0, e1_a == e1_b};
            6'd11: res = {31'b0, e1_a != e1_b};
            6'd13: res = {31'b0, !lt};
            6'd15: res = {31'b0, !ltu};
            default: res = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e1_valid <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                e1_valid <= 1'b0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
            end else begin
                e1_valid <= accept;
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            e1_op <= op_alu;
            e1_a <= rs1_alu;
            e1_b <= rs2_alu;
            e1_tag <= rob_alu;
        end
        if (push) begin
            mem_ans[wr_ptr] <= res;
            mem_tag[wr_ptr] <= e1_tag;
        end
    end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and randomized checks of alu_unit against a queue-based reference model
module tb_alu_unit;
    logic clk = 1'b0, rst, rdy, flush, flag_alu, cdb_grant;
    logic [5:0] op_alu;
    logic [31:0] rs1_alu, rs2_alu, alu_ans;
    logic [3:0] rob_alu, alu_ans_reorder;
    logic alu_busy, alu_ans_flag;
    int n_tests = 0, n_fail = 0, acc;
    bit chk_en = 1'b0;
    typedef struct { logic [3:0] tag; logic [31:0] val; } ent_t;
    ent_t q[$];
    ent_t m_e1;
    bit m_e1v, mb;
    logic [3:0] got[$];
    logic e_busy, e_flag;
    logic [3:0] e_tag;
    logic [31:0] e_ans;

    alu_unit #(.FIFO_DEPTH(4), .ROB_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .flag_alu(flag_alu),
        .op_alu(op_alu), .rs1_alu(rs1_alu), .rs2_alu(rs2_alu), .rob_alu(rob_alu),
        .alu_busy(alu_busy), .alu_ans_flag(alu_ans_flag),
        .alu_ans_reorder(alu_ans_reorder), .alu_ans(alu_ans), .cdb_grant(cdb_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh = int'(b[4:0]);
        logic slt = (a[31] != b[31]) ? a[31] : (a < b);
        logic ult = a < b;
        logic [31:0] sra = (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
        case (op)
            6'd0: return a + b;
            6'd1: return a - b;
            6'd2: return a & b;
            6'd3: return a | b;
            6'd4: return a ^ b;
            6'd5: return a << sh;
            6'd6: return a >> sh;
            6'd7: return sra;
            6'd8: return {31'b0, slt};
            6'd9: return {31'b0, ult};
            6'd10: return {31'b0, a == b};
            6'd11: return {31'b0, a != b};
            6'd12: return {31'b0, slt};
            6'd13: return {31'b0, !slt};
            6'd14: return {31'b0, ult};
            6'd15: return {31'b0, !ult};
            default: return 32'h0;
        endcase
    endfunction

    // reference model: one pending E1 slot plus an in-order result queue
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_e1v = 1'b0;
        end else if (rdy) begin
            if (flush) begin
                q.delete();
                m_e1v = 1'b0;
            end else begin
                mb = (q.size() + int'(m_e1v)) >= 4;
                if (q.size() > 0 && cdb_grant) begin
                    got.push_back(alu_ans_reorder);
                    void'(q.pop_front());
                end
                if (m_e1v) q.push_back(m_e1);
                m_e1v = flag_alu && !mb;
                if (m_e1v) m_e1 = '{rob_alu, ref_alu(op_alu, rs1_alu, rs2_alu)};
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst) begin
            e_busy = (q.size() + int'(m_e1v)) >= 4;
            e_flag = q.size() != 0;
            e_tag = e_flag ? q[0].tag : 4'h0;
            e_ans = e_flag ? q[0].val : 32'h0;
            chk("busy", 32'(alu_busy), 32'(e_busy));
            chk("flag", 32'(alu_ans_flag), 32'(e_flag));
            chk("tag", 32'(alu_ans_reorder), 32'(e_tag));
            chk("ans", alu_ans, e_ans);
        end
    end

    always @(posedge clk) begin
        if (rst && rdy) assert (!(flag_alu && alu_busy)) else $error("FAIL protocol: issue while busy");
    end

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        op_alu = op;
        rs1_alu = a;
        rs2_alu = b;
        rob_alu = t;
        flag_alu = 1'b1;
    endtask

    task automatic fill3();
        cdb_grant = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            drive(6'(t), $urandom, $urandom, 4'(t));
            @(negedge clk);
        end
        flag_alu = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_got(input string nm, input int n);
        chk({nm, "_cnt"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < got.size() && i < n; i++) chk(nm, 32'(got[i]), 32'(i + 1));
    endtask

    initial begin
        logic [5:0] s_op[7] = '{6'd8, 6'd9, 6'd12, 6'd15, 6'd7, 6'd6, 6'd20};
        logic [31:0] s_b[7] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd33, 32'd1};
        logic [31:0] s_x[7] = '{32'd1, 32'd0, 32'd1, 32'd1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0};
        int nt;
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; flag_alu = 1'b0; cdb_grant = 1'b0;
        op_alu = '0; rs1_alu = '0; rs2_alu = '0; rob_alu = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_busy", 32'(alu_busy), 0);
        chk("rst_flag", 32'(alu_ans_flag), 0);
        chk("rst_tag", 32'(alu_ans_reorder), 0);
        chk("rst_ans", alu_ans, 0);
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_flag", 32'(alu_ans_flag), 0);
        end
        cdb_grant = 1'b1;
        drive(6'd0, 32'hFFFFFFFF, 32'd2, 4'd5);
        @(negedge clk);
        flag_alu = 1'b0;
        chk("add_e1_flag", 32'(alu_ans_flag), 0);
        @(negedge clk);
        chk("add_flag", 32'(alu_ans_flag), 1);
        chk("add_ans", alu_ans, 32'h1);
        chk("add_tag", 32'(alu_ans_reorder), 5);
        @(negedge clk);
        chk("add_once", 32'(alu_ans_flag), 0);
        for (int i = 0; i < 7; i++) begin
            drive(s_op[i], 32'hFFFFFFFE, s_b[i], 4'(i));
            @(negedge clk);
            flag_alu = 1'b0;
            @(negedge clk);
            chk($sformatf("sign_op%0d", s_op[i]), alu_ans, s_x[i]);
        end
        @(negedge clk);
        cdb_grant = 1'b0;
        acc = 0;
        for (int t = 1; t <= 6; t++) begin
            drive(6'd0, $urandom, $urandom, 4'(t));
            flag_alu = !alu_busy;
            if (flag_alu) acc++;
            @(negedge clk);
        end
        flag_alu = 1'b0;
        @(negedge clk);
        chk("bp_accepted", 32'(acc), 4);
        chk("bp_busy", 32'(alu_busy), 1);
        got.delete();
        cdb_grant = 1'b1;
        chk("bp_head", 32'(alu_ans_reorder), 1);
        @(negedge clk);
        chk("bp_busy_drop", 32'(alu_busy), 0);
        repeat (4) @(negedge clk);
        chk_got("bp_order", 4);
        cdb_grant = 1'b0;
        got.delete();
        for (int t = 1; t <= 4; t++) begin
            drive(6'd1, $urandom, $urandom, 4'(t));
            @(negedge clk);
        end
        flag_alu = 1'b0;
        cdb_grant = 1'b1;
        chk("full_busy", 32'(alu_busy), 1);
        @(negedge clk);
        chk("full_head", 32'(alu_ans_reorder), 2);
        chk("full_flag", 32'(alu_ans_flag), 1);
        nt = 5;
        repeat (10) begin
            drive(6'd4, $urandom, $urandom, 4'(nt));
            flag_alu = !alu_busy;
            if (flag_alu) nt++;
            @(negedge clk);
        end
        flag_alu = 1'b0;
        repeat (8) @(negedge clk);
        chk_got("full_order", nt - 1);
        got.delete();
        fill3();
        flush = 1'b1; cdb_grant = 1'b1;
        drive(6'd0, 1, 1, 4'd9);
        @(negedge clk);
        flush = 1'b0; flag_alu = 1'b0;
        chk("flush_flag", 32'(alu_ans_flag), 0);
        repeat (4) @(negedge clk);
        chk("flush_none", 32'(got.size()), 0);
        fill3();
        rdy = 1'b0; flush = 1'b1; cdb_grant = 1'b1;
        drive(6'd0, 1, 1, 4'd9);
        @(negedge clk);
        rdy = 1'b1; flush = 1'b0; flag_alu = 1'b0;
        chk("rdy0_flag", 32'(alu_ans_flag), 1);
        repeat (5) @(negedge clk);
        chk_got("rdy0_order", 3);
        cdb_grant = 1'b0;
        drive(6'd0, 7, 8, 4'd1);
        @(negedge clk);
        drive(6'd0, 7, 8, 4'd2);
        @(negedge clk);
        flag_alu = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_flag", 32'(alu_ans_flag), 0);
        chk("mid_rst_busy", 32'(alu_busy), 0);
        chk("mid_rst_ans", alu_ans, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_flag", 32'(alu_ans_flag), 0);
        end
        repeat (3000) begin
            rdy = ($urandom % 8) != 0;
            flush = ($urandom % 32) == 0;
            cdb_grant = ($urandom % 3) != 0;
            op_alu = ($urandom % 10 == 0) ? 6'($urandom) : 6'($urandom % 16);
            rs1_alu = ($urandom % 4 == 0) ? 32'h80000000 >> ($urandom % 2) : $urandom;
            rs2_alu = ($urandom % 4 == 0) ? rs1_alu : $urandom;
            rob_alu = 4'($urandom);
            flag_alu = (($urandom % 4) != 0) && !alu_busy;
            @(negedge clk);
        end
        rdy = 1'b1; flush = 1'b0; flag_alu = 1'b0; cdb_grant = 1'b1;
        repeat (6) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
